// File: rtl/pc_gen.sv
// Program-counter generator: sequential fetch, branch/JAL/JALR/trap redirect,
// misaligned-target trap diversion, redirect counter. PC_TRACE_EN adds a redirect trace buffer.
module pc_gen #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h100),
  parameter int unsigned     CNT_W        = 16,
  parameter int unsigned     TRACE_DEPTH  = 8
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_stall,
  input  logic                            i_branch_en,
  input  logic                            i_jal_en,
  input  logic                            i_jalr_en,
  input  logic [XLEN-1:0]                 i_imm,
  input  logic [XLEN-1:0]                 i_rs1,
  input  logic                            i_trap,
  output logic [XLEN-1:0]                 o_pc,
  output logic [XLEN-1:0]                 o_pc_plus4,
  output logic                            o_misaligned,
  output logic [XLEN-1:0]                 o_bad_target,
  output logic [CNT_W-1:0]                o_redirect_cnt
`ifdef PC_TRACE_EN
  ,
  input  logic [$clog2(TRACE_DEPTH)-1:0]  i_trace_idx,
  output logic [XLEN-1:0]                 o_trace_pc,
  output logic [$clog2(TRACE_DEPTH):0]    o_trace_cnt
`endif
);

  localparam int unsigned     IDX_W     = $clog2(TRACE_DEPTH);
  localparam logic [XLEN-1:0] JALR_MASK = ~XLEN'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  // Trace ring indexing relies on natural pointer wrap.
  if ((TRACE_DEPTH < 2) || ((TRACE_DEPTH & (TRACE_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("pc_gen: TRACE_DEPTH must be a power of two >= 2");
  end

  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  bad_q, bad_d;
  logic             mis_q, mis_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [XLEN-1:0]  pc_plus4;
  logic [XLEN-1:0]  jalr_tgt;
  logic [XLEN-1:0]  rel_tgt;
  logic [XLEN-1:0]  target;
  logic             redirect;
  logic             target_mis;
  logic             record;

  assign pc_plus4 = pc_q + XLEN'(4);
  assign jalr_tgt = (i_rs1 + i_imm) & JALR_MASK;
  assign rel_tgt  = pc_q + i_imm;

  // Next-PC selection: trap > stall > jalr > jal/branch > sequential.
  always_comb begin
    pc_d       = pc_q;
    bad_d      = bad_q;
    mis_d      = 1'b0;
    cnt_d      = cnt_q;
    record     = 1'b0;
    redirect   = i_jalr_en | i_jal_en | i_branch_en;
    target     = i_jalr_en ? jalr_tgt : rel_tgt;
    target_mis = (target[1:0] != 2'b00);

    if (i_trap) begin
      pc_d = TRAP_VECTOR;
    end else if (!i_stall) begin
      if (redirect) begin
        if (target_mis) begin
          pc_d  = TRAP_VECTOR;
          mis_d = 1'b1;
          bad_d = target;
        end else begin
          pc_d   = target;
          record = 1'b1;
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
        end
      end else begin
        pc_d = pc_plus4;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc_q  <= RESET_VECTOR;
      bad_q <= '0;
      mis_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      pc_q  <= pc_d;
      bad_q <= bad_d;
      mis_q <= mis_d;
      cnt_q <= cnt_d;
    end
  end

  assign o_pc           = pc_q;
  assign o_pc_plus4     = pc_plus4;
  assign o_misaligned   = mis_q;
  assign o_bad_target   = bad_q;
  assign o_redirect_cnt = cnt_q;

`ifdef PC_TRACE_EN
  logic [XLEN-1:0]  trace_mem [TRACE_DEPTH];
  logic [IDX_W-1:0] wr_ptr_q;
  logic [IDX_W:0]   trace_cnt_q;
  logic [IDX_W-1:0] rd_ptr;

  // Storage carries no reset; the valid count gates every read.
  always_ff @(posedge i_clk) begin
    if (!i_rst && record) trace_mem[wr_ptr_q] <= pc_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q    <= '0;
      trace_cnt_q <= '0;
    end else if (record) begin
      wr_ptr_q <= wr_ptr_q + IDX_W'(1);
      if (trace_cnt_q != (IDX_W + 1)'(TRACE_DEPTH)) trace_cnt_q <= trace_cnt_q + (IDX_W + 1)'(1);
    end
  end

  // Index 0 is the newest entry, one behind the write pointer.
  assign rd_ptr      = wr_ptr_q - IDX_W'(1) - i_trace_idx;
  assign o_trace_pc  = ({1'b0, i_trace_idx} < trace_cnt_q) ? trace_mem[rd_ptr] : '0;
  assign o_trace_cnt = trace_cnt_q;
`else
  logic unused_record;
  assign unused_record = record;
`endif

endmodule
